// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state encoding, BCD limits and digit widths for the clock set path
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } set_state_t;

    localparam int HR_MAX     = 23;
    localparam int MIN_MAX    = 59;

    localparam int HR_TENS_W  = 2;
    localparam int MIN_TENS_W = 3;
    localparam int ONES_W     = 4;

    localparam int TO_CNT_W   = 8;

endpackage

// File: rtl/clock_set_shadow.sv
// rtl/clock_set_shadow.sv - two-digit BCD shadow register with capture, increment and wrap limit
module clock_set_shadow
    import clock_pkg::*;
#(
    parameter int TENS_W  = 2,
    parameter int MAX_VAL = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              capture_i,
    input  logic              inc_i,
    input  logic [TENS_W-1:0] tens_i,
    input  logic [ONES_W-1:0] ones_i,
    output logic [TENS_W-1:0] tens_o,
    output logic [ONES_W-1:0] ones_o
);

    localparam logic [TENS_W-1:0] MAX_TENS = TENS_W'(MAX_VAL / 10);
    localparam logic [ONES_W-1:0] MAX_ONES = ONES_W'(MAX_VAL % 10);

    logic [TENS_W-1:0] r_tens;
    logic [ONES_W-1:0] r_ones;

    // Capture the live digits, or step the BCD pair with ones->tens carry and wrap at the limit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (capture_i) begin
            r_tens <= tens_i;
            r_ones <= ones_i;
        end else if (inc_i) begin
            if (r_tens == MAX_TENS && r_ones == MAX_ONES) begin
                r_tens <= '0;
                r_ones <= '0;
            end else if (r_ones == ONES_W'(9)) begin
                r_tens <= r_tens + TENS_W'(1);
                r_ones <= '0;
            end else begin
                r_ones <= r_ones + ONES_W'(1);
            end
        end
    end

    assign tens_o = r_tens;
    assign ones_o = r_ones;

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set sequencer; optional session timeout under CLOCK_SET_TIMEOUT_EN
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_TICKS_P = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic                  mode_i,
    input  logic                  inc_i,
    input  logic [HR_TENS_W-1:0]  cur_hr_tens_i,
    input  logic [ONES_W-1:0]     cur_hr_ones_i,
    input  logic [MIN_TENS_W-1:0] cur_min_tens_i,
    input  logic [ONES_W-1:0]     cur_min_ones_i,
    output logic                  cnt_en_o,
    output logic                  nLoad_o,
    output logic [HR_TENS_W-1:0]  load_hr_tens_o,
    output logic [ONES_W-1:0]     load_hr_ones_o,
    output logic [MIN_TENS_W-1:0] load_min_tens_o,
    output logic [ONES_W-1:0]     load_min_ones_o,
    output logic                  blink_hr_o,
    output logic                  blink_min_o,
    output logic [1:0]            state_o
);

    set_state_t r_state;
    set_state_t w_next_state;
    logic       w_capture;
    logic       w_inc_hr;
    logic       w_inc_min;
    logic       w_btn;
    logic       w_in_set;
    logic       w_timeout;
    logic       w_phase_next;
    logic       r_phase;
    logic       r_nload;
    logic       r_blink_hr;
    logic       r_blink_min;

    assign w_btn    = mode_i | inc_i;
    assign w_in_set = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TIMEOUT_LIMIT = TO_CNT_W'(TIMEOUT_TICKS_P);

    logic [TO_CNT_W-1:0] r_to_cnt;

    // Count idle ticks inside a session; any press, session entry or leaving a SET state restarts it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
        end else if (!w_in_set || w_btn ||
                     (w_next_state != ST_SET_HR && w_next_state != ST_SET_MIN)) begin
            r_to_cnt <= '0;
        end else if (tick_i) begin
            r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
        end
    end

    assign w_timeout = w_in_set && (r_to_cnt == TIMEOUT_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and shadow control; mode beats timeout, and both beat a same-cycle increment
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_inc_hr     = 1'b0;
        w_inc_min    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mode_i) begin
                    w_next_state = ST_SET_HR;
                    w_capture    = 1'b1;
                end
            end
            ST_SET_HR: begin
                if (mode_i) begin
                    w_next_state = ST_SET_MIN;
                end else if (w_timeout) begin
                    w_next_state = ST_RUN;
                end else if (inc_i) begin
                    w_inc_hr = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (mode_i) begin
                    w_next_state = ST_COMMIT;
                end else if (w_timeout) begin
                    w_next_state = ST_RUN;
                end else if (inc_i) begin
                    w_inc_min = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Blink phase: toggles on ticks while editing, forced solid on any press and outside sessions
    always_comb begin
        w_phase_next = 1'b0;
        if (w_in_set) begin
            if (w_btn) begin
                w_phase_next = 1'b0;
            end else if (tick_i) begin
                w_phase_next = ~r_phase;
            end else begin
                w_phase_next = r_phase;
            end
        end
    end

    // State, load strobe and blink outputs, all registered from the next-state view
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_nload     <= 1'b1;
            r_phase     <= 1'b0;
            r_blink_hr  <= 1'b0;
            r_blink_min <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_nload     <= (w_next_state != ST_COMMIT);
            r_phase     <= w_phase_next;
            r_blink_hr  <= w_phase_next && (w_next_state == ST_SET_HR);
            r_blink_min <= w_phase_next && (w_next_state == ST_SET_MIN);
        end
    end

    clock_set_shadow #(
        .TENS_W  (HR_TENS_W),
        .MAX_VAL (HR_MAX)
    ) u_shadow_hr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (w_capture),
        .inc_i     (w_inc_hr),
        .tens_i    (cur_hr_tens_i),
        .ones_i    (cur_hr_ones_i),
        .tens_o    (load_hr_tens_o),
        .ones_o    (load_hr_ones_o)
    );

    clock_set_shadow #(
        .TENS_W  (MIN_TENS_W),
        .MAX_VAL (MIN_MAX)
    ) u_shadow_min (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (w_capture),
        .inc_i     (w_inc_min),
        .tens_i    (cur_min_tens_i),
        .ones_i    (cur_min_ones_i),
        .tens_o    (load_min_tens_o),
        .ones_o    (load_min_ones_o)
    );

    assign cnt_en_o    = tick_i && (r_state == ST_RUN);
    assign nLoad_o     = r_nload;
    assign blink_hr_o  = r_blink_hr;
    assign blink_min_o = r_blink_min;
    assign state_o     = r_state;

endmodule
